// File: rtl/instruction_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : instruction_fetch_queue
// Description : Fetch stage that decouples PC generation from decode. It
//               issues sequential fetch requests under a credit limit, queues
//               in-order memory responses with their PCs, and hands them to
//               decode over valid/ready. Branch redirects flush the queue and
//               discard stale in-flight responses.
// Revision    : 1.0 - initial release
// ============================================================================
module instruction_fetch_queue #(
    parameter int unsigned            ADDR_WIDTH  = 64,
    parameter int unsigned            INSTR_WIDTH = 32,
    parameter int unsigned            DEPTH       = 4,
    parameter logic [ADDR_WIDTH-1:0]  RESET_PC    = '0,
    parameter int unsigned            INC         = 4
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   Branchreg,
    input  logic [ADDR_WIDTH-1:0]  PC_branch_in,
    output logic                   imem_req_valid,
    input  logic                   imem_req_ready,
    output logic [ADDR_WIDTH-1:0]  imem_req_addr,
    input  logic                   imem_resp_valid,
    input  logic [INSTR_WIDTH-1:0] imem_resp_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [INSTR_WIDTH-1:0] instruction_out,
    output logic [ADDR_WIDTH-1:0]  PC_out,
    output logic [ADDR_WIDTH-1:0]  PC_branch_link_out
);

    localparam int unsigned           C_PTR_W = $clog2(DEPTH);
    localparam int unsigned           C_CNT_W = $clog2(DEPTH) + 1;
    localparam logic [ADDR_WIDTH-1:0] C_INC   = ADDR_WIDTH'(INC);
    localparam logic [C_CNT_W:0]      C_CREDIT_LIMIT = (C_CNT_W + 1)'(DEPTH);
    localparam logic [C_CNT_W-1:0]    C_FULL  = C_CNT_W'(DEPTH);

    // Control state
    logic [ADDR_WIDTH-1:0] r_fetch_pc;
    logic [ADDR_WIDTH-1:0] r_resp_pc;
    logic [C_CNT_W-1:0]    r_count;
    logic [C_CNT_W-1:0]    r_outstanding;
    logic [C_CNT_W-1:0]    r_drop_cnt;
    logic [C_PTR_W-1:0]    r_head;
    logic [C_PTR_W-1:0]    r_tail;

    // Queue storage (data path only, no reset needed)
    logic [INSTR_WIDTH-1:0] r_mem_instr [DEPTH];
    logic [ADDR_WIDTH-1:0]  r_mem_pc    [DEPTH];

    // Handshake / event decode
    logic [C_CNT_W:0] w_credit_used;
    logic             w_req_valid;
    logic             w_req_fire;
    logic             w_out_valid;
    logic             w_pop;
    logic             w_push;
    logic             w_drop;

    // Queue entries plus in-flight requests may never exceed DEPTH, which
    // guarantees every non-stale response has a free slot to land in.
    assign w_credit_used = {1'b0, r_count} + {1'b0, r_outstanding};
    assign w_req_valid   = !reset && !Branchreg && (w_credit_used < C_CREDIT_LIMIT);
    assign w_req_fire    = w_req_valid && imem_req_ready;
    assign w_out_valid   = !reset && !Branchreg && (r_count != '0);
    assign w_pop         = w_out_valid && out_ready;
    // A response in a redirect cycle is stale by definition and is never pushed.
    assign w_push        = imem_resp_valid && !Branchreg && (r_drop_cnt == '0);
    assign w_drop        = imem_resp_valid && !Branchreg && (r_drop_cnt != '0);

    // Control registers: PCs, occupancy, in-flight tracking and redirect flush
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_fetch_pc    <= RESET_PC;
            r_resp_pc     <= RESET_PC;
            r_count       <= '0;
            r_outstanding <= '0;
            r_drop_cnt    <= '0;
            r_head        <= '0;
            r_tail        <= '0;
        end else begin
            r_outstanding <= r_outstanding + C_CNT_W'(w_req_fire) - C_CNT_W'(imem_resp_valid);
            if (Branchreg) begin
                // Every request still in flight (minus one answering now) is stale.
                r_count    <= '0;
                r_head     <= '0;
                r_tail     <= '0;
                r_fetch_pc <= PC_branch_in;
                r_resp_pc  <= PC_branch_in;
                r_drop_cnt <= r_outstanding - C_CNT_W'(imem_resp_valid);
            end else begin
                if (w_req_fire) begin
                    r_fetch_pc <= r_fetch_pc + C_INC;
                end
                if (w_push) begin
                    r_resp_pc <= r_resp_pc + C_INC;
                    r_tail    <= r_tail + C_PTR_W'(1);
                end
                if (w_pop) begin
                    r_head <= r_head + C_PTR_W'(1);
                end
                if (w_drop) begin
                    r_drop_cnt <= r_drop_cnt - C_CNT_W'(1);
                end
                r_count <= r_count + C_CNT_W'(w_push) - C_CNT_W'(w_pop);
            end
        end
    end

    // Queue write port: store the response with the PC it was fetched from
    always_ff @(posedge clock) begin
        if (w_push) begin
            r_mem_instr[r_tail] <= imem_resp_data;
            r_mem_pc[r_tail]    <= r_resp_pc;
        end
    end

    // A push into a full queue that is not popping means the credit logic broke.
    a_no_overflow : assert property (@(posedge clock) disable iff (reset)
        !(w_push && !w_pop && (r_count == C_FULL)));

    assign imem_req_valid     = w_req_valid;
    assign imem_req_addr      = r_fetch_pc;
    assign out_valid          = w_out_valid;
    assign instruction_out    = r_mem_instr[r_head];
    assign PC_out             = r_mem_pc[r_head];
    assign PC_branch_link_out = r_mem_pc[r_head] + C_INC;

endmodule
`default_nettype wire

// File: tb/tb_instruction_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_instruction_fetch_queue
// Description : Randomized bench for instruction_fetch_queue. A memory model
//               answers requests in order with random latency; an epoch-tagged
//               reference queue predicts what decode must see.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instruction_fetch_queue;

    localparam int          C_DEPTH    = 4;
    localparam logic [63:0] C_RESET_PC = 64'hFFFF_FFFF_FFFF_FFF8;
    localparam logic [63:0] C_INC      = 64'd4;

    logic        clock = 1'b0;
    logic        reset;
    logic        Branchreg;
    logic [63:0] PC_branch_in;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [63:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] instruction_out;
    logic [63:0] PC_out;
    logic [63:0] PC_branch_link_out;

    instruction_fetch_queue #(
        .ADDR_WIDTH  (64),
        .INSTR_WIDTH (32),
        .DEPTH       (C_DEPTH),
        .RESET_PC    (C_RESET_PC),
        .INC         (4)
    ) u_dut (
        .clock              (clock),
        .reset              (reset),
        .Branchreg          (Branchreg),
        .PC_branch_in       (PC_branch_in),
        .imem_req_valid     (imem_req_valid),
        .imem_req_ready     (imem_req_ready),
        .imem_req_addr      (imem_req_addr),
        .imem_resp_valid    (imem_resp_valid),
        .imem_resp_data     (imem_resp_data),
        .out_valid          (out_valid),
        .out_ready          (out_ready),
        .instruction_out    (instruction_out),
        .PC_out             (PC_out),
        .PC_branch_link_out (PC_branch_link_out)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [63:0] addr;
        int          epoch;
        int          due;
    } req_t;

    typedef struct {
        logic [63:0] pc;
        logic [31:0] data;
    } ent_t;

    req_t        pend[$];      // requests accepted by memory, oldest first
    ent_t        mq[$];        // what decode should see, head first
    int          cur_epoch;
    logic [63:0] exp_fetch_pc;
    int          cyc;
    int          delivered;

    int unsigned p_br, p_ord, p_rrdy, p_resp, lat_lo, lat_hi;
    logic        force_br;
    logic [63:0] force_tgt;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=%h expected=%h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [31:0] fdata(input logic [63:0] a);
        return a[31:0] ^ {a[47:32], a[63:48]} ^ 32'h5A3C_96E1;
    endfunction

    function automatic logic [63:0] pick_target();
        case ($urandom_range(3))
            0:       return 64'h1000;
            1:       return 64'h2000;
            2:       return 64'hFFFF_FFFF_FFFF_FFF4;
            default: return {$urandom, $urandom};
        endcase
    endfunction

    // One clock: drive inputs at negedge, check, then advance the model.
    task automatic step();
        logic exp_req;
        logic exp_out;
        req_t p;
        ent_t e;
        @(negedge clock);
        Branchreg       = force_br || ($urandom_range(99) < p_br);
        PC_branch_in    = force_br ? force_tgt : pick_target();
        force_br        = 1'b0;
        out_ready       = ($urandom_range(99) < p_ord);
        imem_req_ready  = ($urandom_range(99) < p_rrdy);
        imem_resp_valid = (pend.size() != 0) && (pend[0].due <= cyc) && ($urandom_range(99) < p_resp);
        imem_resp_data  = imem_resp_valid ? fdata(pend[0].addr) : $urandom;
        #1;
        exp_req = !Branchreg && (mq.size() + pend.size() < C_DEPTH);
        check("req_valid", imem_req_valid, exp_req);
        if (exp_req) check("req_addr", imem_req_addr, exp_fetch_pc);
        exp_out = !Branchreg && (mq.size() != 0);
        check("out_valid", out_valid, exp_out);
        if (exp_out) begin
            check("pc_out", PC_out, mq[0].pc);
            check("instr_out", instruction_out, mq[0].data);
            check("link_out", PC_branch_link_out, mq[0].pc + C_INC);
        end
        if (exp_out && out_ready) begin
            void'(mq.pop_front());
            delivered++;
        end
        if (imem_resp_valid) begin
            p = pend.pop_front();
            if (!Branchreg && p.epoch == cur_epoch) begin
                e.pc   = p.addr;
                e.data = fdata(p.addr);
                mq.push_back(e);
            end
        end
        if (Branchreg) begin
            mq.delete();
            cur_epoch++;
            exp_fetch_pc = PC_branch_in;
        end
        if (exp_req && imem_req_ready) begin
            p.addr  = exp_fetch_pc;
            p.epoch = cur_epoch;
            p.due   = cyc + int'($urandom_range(lat_hi, lat_lo));
            pend.push_back(p);
            exp_fetch_pc = exp_fetch_pc + C_INC;
        end
        cyc++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic knobs(input int unsigned br, input int unsigned ord, input int unsigned rrdy,
                         input int unsigned resp, input int unsigned lo, input int unsigned hi);
        p_br = br; p_ord = ord; p_rrdy = rrdy; p_resp = resp; lat_lo = lo; lat_hi = hi;
    endtask

    task automatic redirect(input logic [63:0] tgt);
        force_br  = 1'b1;
        force_tgt = tgt;
        step();
    endtask

    // Asynchronous reset in the middle of traffic with entries queued.
    task automatic reset_mid();
        knobs(0, 0, 100, 100, 1, 1);
        for (int i = 0; i < 60 && mq.size() < 2; i++) step();
        @(negedge clock);
        Branchreg = 1'b0; imem_resp_valid = 1'b0; out_ready = 1'b0; imem_req_ready = 1'b0;
        #2 reset = 1'b1;
        #1;
        check("rst_mid_out_valid", out_valid, 1'b0);
        check("rst_mid_req_valid", imem_req_valid, 1'b0);
        pend.delete();
        mq.delete();
        cur_epoch++;
        exp_fetch_pc = C_RESET_PC;
        @(negedge clock);
        reset = 1'b0;
        #1;
        check("rst_mid_restart_addr", imem_req_addr, C_RESET_PC);
        check("rst_mid_restart_valid", imem_req_valid, 1'b1);
    endtask

    initial begin
        reset = 1'b1; Branchreg = 1'b0; PC_branch_in = '0; imem_req_ready = 1'b0;
        imem_resp_valid = 1'b0; imem_resp_data = '0; out_ready = 1'b0;
        force_br = 1'b0; force_tgt = '0;
        cur_epoch = 0; exp_fetch_pc = C_RESET_PC; cyc = 0; delivered = 0;
        knobs(0, 100, 100, 100, 1, 1);
        @(negedge clock);
        @(negedge clock);
        #1;
        check("reset_out_valid", out_valid, 1'b0);
        check("reset_req_valid", imem_req_valid, 1'b0);
        @(negedge clock);
        reset = 1'b0;
        #1;
        check("first_req_addr", imem_req_addr, C_RESET_PC);

        // Streaming with 1-cycle memory; exercises the PC wrap from the reset PC.
        knobs(0, 100, 100, 100, 1, 1);
        run(40);
        // Decode stall fills the queue, then drains in order.
        knobs(0, 0, 100, 100, 1, 1);
        run(20);
        knobs(0, 100, 100, 100, 1, 1);
        run(20);
        // Three requests in flight at 3-cycle latency, then redirect.
        knobs(0, 100, 100, 100, 3, 3);
        for (int i = 0; i < 20 && pend.size() < 3; i++) step();
        redirect(64'h1000);
        run(20);
        // Redirect with a response in the same cycle, second redirect two cycles later.
        knobs(0, 100, 100, 100, 1, 1);
        run(3);
        redirect(64'h1000);
        run(1);
        redirect(64'h2000);
        run(20);
        // Redirect that wraps past 2^64.
        redirect(64'hFFFF_FFFF_FFFF_FFF4);
        run(20);
        // Random mix of everything.
        knobs(5, 70, 70, 70, 1, 5);
        run(2000);
        // Back-to-back redirects.
        knobs(60, 80, 80, 80, 1, 3);
        run(40);
        reset_mid();
        knobs(5, 70, 70, 70, 1, 5);
        run(500);

        check("progress", delivered > 300, 1'b1);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/instruction_fetch_queue.md
Name: instruction_fetch_queue

Overview:
Parametrised fetch stage that decouples PC generation from decode.
- Issues sequential fetch requests to an instruction memory with variable, in-order response latency.
- Buffers returned instructions with their PCs in a DEPTH-entry queue and hands them to decode over a valid/ready handshake.
- Handles branch redirects by flushing the queue and discarding stale in-flight responses.

Parameters:
ADDR_WIDTH, 64, PC and memory address width
INSTR_WIDTH, 32, instruction word width
DEPTH, 4, queue entries and max outstanding requests; power of two, >=2
RESET_PC, 0, PC fetched first after reset
INC, 4, sequential PC increment

Ports:
clock  in  1  single clock, rising edge
reset  in  1  asynchronous, active-high
Branchreg  in  1  redirect strobe, one cycle per redirect
PC_branch_in  in  ADDR_WIDTH  redirect target, sampled when Branchreg=1
imem_req_valid  out  1  fetch request valid
imem_req_ready  in  1  memory accepts request
imem_req_addr  out  ADDR_WIDTH  fetch address
imem_resp_valid  in  1  response valid; exactly one per accepted request, in order, >=1 cycle after acceptance
imem_resp_data  in  INSTR_WIDTH  fetched instruction
out_valid  out  1  queue head valid to decode
out_ready  in  1  decode accepts head
instruction_out  out  INSTR_WIDTH  head instruction
PC_out  out  ADDR_WIDTH  head PC
PC_branch_link_out  out  ADDR_WIDTH  PC_out + INC, mod 2^ADDR_WIDTH

Behaviour:
Reset:
- fetch_pc and resp_pc reset to RESET_PC.
- Queue count, outstanding count and drop_cnt reset to 0.
- out_valid=0 and imem_req_valid=0 while reset is asserted.
- imem_req_addr=RESET_PC on the first cycle after reset.
- Reset mid-operation abandons all state. Responses arriving after reset deasserts are a bench error.

Issue:
- imem_req_valid = !Branchreg && (count + outstanding < DEPTH).
- imem_req_addr = fetch_pc.
- On handshake: fetch_pc += INC (wraps mod 2^ADDR_WIDTH) and outstanding increments.

Response:
- Each imem_resp_valid decrements outstanding.
- If drop_cnt>0: discard the response and decrement drop_cnt.
- Else: push {resp_pc, imem_resp_data} into the queue and resp_pc += INC.
- The credit rule guarantees no overflow. Push to a full queue is an assertion failure.

Output:
- out_valid = (count!=0) && !Branchreg.
- Head is popped when out_valid && out_ready.
- Push and pop in the same cycle are allowed, including at count=DEPTH-1 and with a full queue popping.
- Outputs are a registered queue head. Zero latency from push to visibility is not required: a pushed entry appears on out_valid the cycle after the response.
- Minimum fetch-to-decode latency: request cycle + memory latency + 1.

Redirect (Branchreg=1):
- Queue count is cleared and no pop occurs.
- No request is issued that cycle.
- fetch_pc <= PC_branch_in and resp_pc <= PC_branch_in.
- drop_cnt <= outstanding - imem_resp_valid. Any response in the redirect cycle is discarded, not pushed.
- Redirect while drop_cnt>0: same formula, which supersedes the old drop_cnt (outstanding already includes the older stale requests).
- From the next cycle, issue resumes at the target once credit allows.
- Branchreg held for consecutive cycles: each cycle is a redirect, and the last target wins.

Arithmetic:
- All PC arithmetic is unsigned, mod 2^ADDR_WIDTH.
- PC_branch_in is used unaligned as-is.

Test Plan:
- Reset release, imem_req_ready=1, 1-cycle memory latency, out_ready=1 -> imem_req_addr 0,4,8,...; decode sees PC_out 0,4,8 with matching data; PC_branch_link_out 4,8,12; no bubbles after the pipeline fills.
- out_ready=0 for 20 cycles -> queue fills to DEPTH=4; requests stop once count+outstanding=4; on release, PCs 0,4,8,12 drain in order with no loss or duplication.
- 3-cycle memory latency, 3 requests outstanding, Branchreg=1 with PC_branch_in=0x1000 -> the 3 stale responses are dropped; first out_valid PC_out=0x1000; next request addr=0x1000.
- Redirect in the same cycle a response arrives, then a second redirect to 0x2000 two cycles later -> all earlier responses are discarded; output resumes at 0x2000.
- RESET_PC=2^64-8, INC=4 -> PCs FFFF_FFFF_FFFF_FFF8, FFFF_FFFF_FFFF_FFFC, 0; PC_branch_link_out wraps to 0 at head FFFF_FFFF_FFFF_FFFC.
- Reset asserted asynchronously mid-stream with the queue holding 2 entries -> out_valid and imem_req_valid drop immediately; after release, fetch restarts at RESET_PC.
